// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2^WIDTH accepted
// bits and presents the count with a valid/ready handshake.
module sc_bitstream_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   value
);

  // state | meaning
  // IDLE  | waiting for start; value holds the last result
  // ACCUM | counting valid bits of the current window
  // HOLD  | result presented, waiting for out_ready
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [WIDTH:0] LAST_IDX = {1'b0, {WIDTH{1'b1}}};

  state_t           state;
  logic [WIDTH:0]   sample_cnt;
  logic [WIDTH:0]   ones_cnt;
  logic [WIDTH:0]   bit_ext;

  assign bit_ext = {{WIDTH{1'b0}}, bit_in};

  // busy/out_valid are updated together with state so they are pure flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      ones_cnt   <= '0;
      value      <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sample_cnt <= '0;
            ones_cnt   <= '0;
            state      <= ACCUM;
            busy       <= 1'b1;
          end
        end
        ACCUM: begin
          if (bit_valid) begin
            sample_cnt <= sample_cnt + 1'b1;
            ones_cnt   <= ones_cnt + bit_ext;
            if (sample_cnt == LAST_IDX) begin
              value     <= ones_cnt + bit_ext;
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Bench for sc_bitstream_decoder (WIDTH=3): directed windows plus random
// traffic, every cycle compared against a queue-based window model.
module tb_sc_bitstream_decoder;
  localparam int W = 3;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst, start, bit_in, bit_valid, out_ready;
  logic         busy, out_valid;
  logic [W:0]   value;

  int vectors = 0;
  int miscompares = 0;

  // reference: 0 idle, 1 collecting, 2 result pending
  int           phase = 0;
  bit           win_q[$];
  logic [W:0]   m_val = '0;

  sc_bitstream_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .value     (value)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic r, s, bv, bi, rdy);
    int ones;
    if (r) begin
      phase = 0;
      win_q.delete();
      m_val = '0;
    end else begin
      case (phase)
        0: if (s) begin phase = 1; win_q.delete(); end
        1: if (bv) begin
             win_q.push_back(bi);
             if (win_q.size() == N) begin
               ones = 0;
               foreach (win_q[i]) ones += int'(win_q[i]);
               m_val = ones[W:0];
               phase = 2;
             end
           end
        default: if (rdy) phase = 0;
      endcase
    end
  endtask

  task automatic check_outputs(input string tag);
    logic       e_busy, e_ov;
    e_busy = (phase != 0);
    e_ov   = (phase == 2);
    vectors++;
    assert (busy === e_busy) else begin
      miscompares++;
      $error("FAIL %s busy observed=%0b expected=%0b", tag, busy, e_busy);
    end
    vectors++;
    assert (out_valid === e_ov) else begin
      miscompares++;
      $error("FAIL %s out_valid observed=%0b expected=%0b", tag, out_valid, e_ov);
    end
    vectors++;
    assert (value === m_val) else begin
      miscompares++;
      $error("FAIL %s value observed=%0d expected=%0d", tag, value, m_val);
    end
  endtask

  task automatic step(input string tag, input logic r, s, bv, bi, rdy);
    rst = r; start = s; bit_valid = bv; bit_in = bi; out_ready = rdy;
    @(posedge clk);
    model_edge(r, s, bv, bi, rdy);
    #1;
    check_outputs(tag);
  endtask

  task automatic expect_fixed(input string tag, input logic e_busy, e_ov,
                              input logic [W:0] e_val);
    vectors++;
    assert (busy === e_busy && out_valid === e_ov && value === e_val) else begin
      miscompares++;
      $error("FAIL %s observed busy=%0b ov=%0b value=%0d expected busy=%0b ov=%0b value=%0d",
             tag, busy, out_valid, value, e_busy, e_ov, e_val);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b0;

    // reset with every other input active: reset must win
    step("reset", 1, 1, 1, 1, 1);
    step("reset", 1, 0, 0, 0, 0);
    expect_fixed("reset_state", 0, 0, 0);
    step("idle", 0, 0, 1, 1, 1);

    // 8 valid ones; the valid bit in the start cycle is ignored
    step("ones_start", 0, 1, 1, 1, 0);
    for (int i = 0; i < N; i++) step("ones_win", 0, 0, 1, 1, 0);
    expect_fixed("ones_value8", 1, 1, 4'd8);
    step("ones_accept", 0, 0, 0, 0, 1);
    expect_fixed("ones_idle", 0, 0, 4'd8);

    // all zeros, then alternating 1,0
    step("zeros_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step("zeros_win", 0, 0, 1, 0, 0);
    expect_fixed("zeros_value0", 1, 1, 4'd0);
    step("zeros_accept", 0, 0, 0, 0, 1);
    step("alt_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step("alt_win", 0, 0, 1, logic'(i % 2 == 0), 0);
    expect_fixed("alt_value4", 1, 1, 4'd4);
    step("alt_accept", 0, 0, 0, 0, 1);

    // gapped ones over a 15-cycle span
    step("gap_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 2 * N - 1; i++)
      step("gap_win", 0, 0, logic'(i % 2 == 0), logic'(i % 2 == 0), 0);
    expect_fixed("gap_value8", 1, 1, 4'd8);
    step("gap_accept", 0, 0, 0, 0, 1);

    // backpressure: result held while out_ready is low
    step("bp_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step("bp_win", 0, 0, 1, 1'($urandom), 0);
    for (int i = 0; i < 5; i++) step("bp_hold", 0, 0, 1, 1, 0);
    step("bp_accept", 0, 0, 0, 0, 1);
    step("bp_idle", 0, 0, 0, 0, 0);

    // reset mid-window discards partial count
    step("rst_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("rst_partial", 0, 0, 1, 1, 0);
    step("rst_mid", 1, 0, 1, 1, 0);
    expect_fixed("rst_cleared", 0, 0, 4'd0);
    step("fresh_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step("fresh_win", 0, 0, 1, 1, 0);
    expect_fixed("fresh_value8", 1, 1, 4'd8);
    step("fresh_accept", 0, 0, 0, 0, 1);

    // start pulses during ACCUM and HOLD are ignored
    step("ign_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step("ign_win", 0, logic'(i % 3 == 0), 1, logic'(i < 3), 0);
    step("ign_hold", 0, 1, 0, 0, 0);
    step("ign_accept", 0, 1, 0, 0, 1);
    expect_fixed("ign_idle", 0, 0, 4'd3);
    step("ign_after", 0, 0, 0, 0, 0);

    // reset while a result is pending
    step("rh_start", 0, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) step("rh_win", 0, 0, 1, 1, 0);
    step("rh_rst", 1, 0, 0, 0, 1);
    expect_fixed("rh_cleared", 0, 0, 4'd0);

    // random traffic
    for (int i = 0; i < 500; i++)
      step("random", logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 3) != 0), 1'($urandom), logic'($urandom_range(0, 2) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
